// File: rtl/pipe_fwd_chain_pkg.sv
// Shared constants, stage tag record and counter helper for the pipe_fwd_chain controller.
package pipe_fwd_pkg;

  localparam int unsigned DEF_STAGES = 32'd3;
  localparam int unsigned DEF_DW     = 32'd32;
  localparam int unsigned DEF_RW     = 32'd5;
  localparam int unsigned DEF_NRP    = 32'd2;

  // Tags carry a fixed-width destination so the record type is shared; RW must not exceed TAG_RW.
  localparam int unsigned TAG_RW = 32'd8;

  localparam logic [TAG_RW-1:0] REG_ZERO = {TAG_RW{1'b0}};

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [TAG_RW-1:0] dest;
  } stage_tag_t;

  localparam stage_tag_t TAG_ZERO = '{valid: 1'b0, we: 1'b0, dest: REG_ZERO};

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/pipe_fwd_chain_if.sv
// Decode-side bundle: instruction offer/accept plus read-port forwarding results.
interface pipe_fwd_chain_if #(
  parameter int unsigned DW  = 32'd32,
  parameter int unsigned RW  = 32'd5,
  parameter int unsigned NRP = 32'd2
) ();

  logic              in_valid;
  logic              in_ready;
  logic              in_we;
  logic [RW-1:0]     in_dest;
  logic [NRP*RW-1:0] raddr;
  logic [NRP-1:0]    fwd_hit;
  logic [NRP*DW-1:0] fwd_data;
  logic              fwd_stall;

  modport master (
    output in_valid, in_we, in_dest, raddr,
    input  in_ready, fwd_hit, fwd_data, fwd_stall
  );

  modport slave (
    input  in_valid, in_we, in_dest, raddr,
    output in_ready, fwd_hit, fwd_data, fwd_stall
  );

endinterface

// File: rtl/pipe_fwd_chain_fwd_match.sv
// Priority search of stage tags for one read port; the youngest (lowest index) producer wins.
module fwd_match
  import pipe_fwd_pkg::*;
#(
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned IW     = (STAGES > 32'd1) ? $clog2(STAGES) : 32'd1
) (
  input  stage_tag_t [STAGES-1:0] tags_i,
  input  logic [STAGES-1:0]       res_valid_i,
  input  logic [TAG_RW-1:0]       raddr_i,
  output logic                    hit_o,
  output logic                    pend_o,
  output logic [IW-1:0]           idx_o
);

  logic          found_s;
  logic [IW-1:0] idx_s;

  // Scan oldest to youngest so the last match seen is the youngest producer
  always_comb begin
    logic match_v;
    found_s = 1'b0;
    idx_s   = {IW{1'b0}};
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      match_v = tags_i[k].valid & tags_i[k].we & (tags_i[k].dest == raddr_i) &
                (raddr_i != REG_ZERO);
      found_s = found_s | match_v;
      idx_s   = match_v ? IW'(k) : idx_s;
    end
  end

  assign hit_o  = found_s & res_valid_i[idx_s];
  assign pend_o = found_s & ~res_valid_i[idx_s];
  assign idx_o  = idx_s;

endmodule

// File: rtl/pipe_fwd_chain.sv
// N-stage valid/allow_in controller with write-back forwarding and load-use stall.
// Optional perf counters are built only when PIPE_FWD_PERF_CNT_EN is defined.
module pipe_fwd_chain
  import pipe_fwd_pkg::*;
#(
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned RW     = DEF_RW,
  parameter int unsigned NRP    = DEF_NRP
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_fwd_chain_if.slave      dec,
  input  logic [STAGES-1:0]    ready_go,
  input  logic [STAGES-1:0]    res_valid,
  input  logic [STAGES*DW-1:0] res_data,
  input  logic                 out_allow,
  output logic [STAGES-1:0]    stage_valid,
  output logic [STAGES-1:0]    stage_allow_in,
  input  logic                 flush,
  input  logic [STAGES-1:0]    flush_mask,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_retire_cnt
);

  localparam int unsigned IW = (STAGES > 32'd1) ? $clog2(STAGES) : 32'd1;

  stage_tag_t [STAGES-1:0] tag_q;
  stage_tag_t [STAGES-1:0] tag_d;
  stage_tag_t [STAGES-1:0] src_s;
  logic [STAGES-1:0]       allow_s;
  logic [STAGES-1:0]       kill_s;
  logic [NRP-1:0]          hit_s;
  logic [NRP-1:0]          pend_s;
  logic [IW-1:0]           idx_s [NRP];
  logic [NRP*DW-1:0]       fwd_data_s;
  logic                    stall_s;
  logic                    in_ready_s;

  assign kill_s = {STAGES{flush}} & flush_mask;

  // allow_in ripples from the retiring end back toward decode
  always_comb begin
    logic chain_v;
    allow_s = {STAGES{1'b0}};
    chain_v = ~tag_q[STAGES-1].valid | (ready_go[STAGES-1] & out_allow);
    allow_s[STAGES-1] = chain_v;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      chain_v    = ~tag_q[k].valid | (ready_go[k] & chain_v);
      allow_s[k] = chain_v;
    end
  end

  for (genvar p = 0; p < int'(NRP); p++) begin : g_port
    fwd_match #(.STAGES(STAGES), .IW(IW)) u_match (
      .tags_i      (tag_q),
      .res_valid_i (res_valid),
      .raddr_i     (TAG_RW'(dec.raddr[p*RW +: RW])),
      .hit_o       (hit_s[p]),
      .pend_o      (pend_s[p]),
      .idx_o       (idx_s[p])
    );
  end

  // Forwarded data is zero unless the winning producer already has its result
  always_comb begin
    fwd_data_s = {NRP*DW{1'b0}};
    for (int p = 0; p < int'(NRP); p++) begin
      if (hit_s[p]) begin
        fwd_data_s[p*DW +: DW] = res_data[int'(idx_s[p])*int'(DW) +: DW];
      end else begin
        fwd_data_s[p*DW +: DW] = {DW{1'b0}};
      end
    end
  end

  assign stall_s       = dec.in_valid & (|pend_s);
  assign in_ready_s    = allow_s[0] & ~stall_s;
  assign dec.in_ready  = in_ready_s;
  assign dec.fwd_hit   = hit_s;
  assign dec.fwd_data  = fwd_data_s;
  assign dec.fwd_stall = stall_s;

  // Candidate tag offered to each stage; a squashed predecessor offers a bubble
  always_comb begin
    src_s    = {STAGES{TAG_ZERO}};
    src_s[0] = '{valid: dec.in_valid & ~stall_s, we: dec.in_we, dest: TAG_RW'(dec.in_dest)};
    for (int k = 1; k < int'(STAGES); k++) begin
      src_s[k] = '{valid: tag_q[k-1].valid & ready_go[k-1] & ~kill_s[k-1],
                   we:    tag_q[k-1].we,
                   dest:  tag_q[k-1].dest};
    end
  end

  // Flush beats load; an empty load keeps the stale we/dest fields
  always_comb begin
    tag_d = tag_q;
    for (int k = 0; k < int'(STAGES); k++) begin
      if (kill_s[k]) begin
        tag_d[k].valid = 1'b0;
      end else if (allow_s[k] & src_s[k].valid) begin
        tag_d[k] = src_s[k];
      end else if (allow_s[k]) begin
        tag_d[k].valid = 1'b0;
      end else begin
        tag_d[k] = tag_q[k];
      end
    end
  end

  // Stage tag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= {STAGES{TAG_ZERO}};
    end else begin
      tag_q <= tag_d;
    end
  end

  // Occupancy view of the tag registers
  always_comb begin
    stage_valid = {STAGES{1'b0}};
    for (int k = 0; k < int'(STAGES); k++) begin
      stage_valid[k] = tag_q[k].valid;
    end
  end

  assign stage_allow_in = allow_s;

`ifdef PIPE_FWD_PERF_CNT_EN
  logic        retire_s;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  assign retire_s = tag_q[STAGES-1].valid & ready_go[STAGES-1] & out_allow & ~kill_s[STAGES-1];

  // Saturating event counters
  always_comb begin
    stall_cnt_d  = (dec.in_valid & ~in_ready_s) ? sat_inc32(stall_cnt_q) : stall_cnt_q;
    retire_cnt_d = retire_s ? sat_inc32(retire_cnt_q) : retire_cnt_q;
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_retire_cnt = retire_cnt_q;
`else
  assign perf_stall_cnt  = 32'd0;
  assign perf_retire_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_fwd_chain.md
Name: pipe_fwd_chain

Overview:
- Parametrised successor to the fixed five-stage hand-wired pipeline top.
- Generalises the per-stage valid/allow_in handshake and the per-stage write-back forwarding buses (the EXE/MEM/WB write buses) into one N-stage controller.
- Sits between decode and the execution stages. It tracks the valid, destination and write-enable of every in-flight instruction, generates every allow_in, and resolves register read ports to forward, stall or register file.
- Stage datapaths stay outside the block and feed results back in.

Parameters:
- STAGES, 3, number of tracked stages after decode (stage 0 is youngest).
- DW, 32, result data width.
- RW, 5, register address width; register 0 is never forwarded.
- NRP, 2, number of decode read ports.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage-0 allow_in.
- in_we  in  1  instruction writes a register.
- in_dest  in  RW  destination register.
- ready_go  in  STAGES  per-stage "work finished" flags.
- res_valid  in  STAGES  per-stage "result known" flags (e.g. a load before MEM is 0).
- res_data  in  STAGES*DW  per-stage results, stage k at [k*DW +: DW].
- out_allow  in  1  downstream acceptance of the last stage.
- stage_valid  out  STAGES  occupancy per stage.
- stage_allow_in  out  STAGES  allow_in per stage.
- flush  in  1  squash stages 0..FLUSH_MASK-selected.
- flush_mask  in  STAGES  stages to squash on flush.
- raddr  in  NRP*RW  decode read addresses.
- fwd_hit  out  NRP  forward valid per port.
- fwd_data  out  NRP*DW  forwarded data.
- fwd_stall  out  1  a matching producer has no result yet; decode must hold.
- perf_stall_cnt  out  32  see Optional Feature.
- perf_retire_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high):
  - valid, we and dest cleared in every stage.
  - All counters are 0.
  - in_ready = 1, stage_valid = 0, fwd_hit = 0, fwd_stall = 0.
- Handshake is combinational:
  - allow_in[STAGES-1] = !valid[S-1] | (ready_go[S-1] & out_allow).
  - allow_in[k] = !valid[k] | (ready_go[k] & allow_in[k+1]).
  - in_ready = allow_in[0] & !fwd_stall.
- Stage k latches on a posedge when allow_in[k] is high:
  - Stage 0 valid_next = in_valid & !fwd_stall.
  - Stage k>0 valid_next = valid[k-1] & ready_go[k-1].
  - dest/we are captured from the predecessor only when that predecessor's valid_next is 1; otherwise they hold.
- Retire: valid[S-1] & ready_go[S-1] & out_allow.
- Flush:
  - Same-edge flush wins over any load: valid_next = 0 for every masked stage.
  - An unmasked stage whose predecessor is masked receives a bubble.
  - in_valid is ignored that cycle if bit 0 is set.
- Forwarding, per port p (combinational, latency 0):
  - Candidates are stages with valid & we & dest==raddr[p] & raddr[p]!=0.
  - The lowest k (youngest) wins.
  - Winner res_valid=1: fwd_hit[p]=1, fwd_data[p]=res_data[k].
  - Winner res_valid=0: fwd_hit[p]=0 and fwd_stall=1.
  - No candidate: fwd_hit=0 and fwd_data=0.
- fwd_stall is the OR over ports and is gated by in_valid.
- Holding stages keep their contents unchanged. There is no wrap-around: the block has no storage beyond STAGES entries.

Optional Feature:
- Macro PIPE_FWD_PERF_CNT_EN.
- When defined:
  - perf_stall_cnt increments each cycle in_valid & !in_ready.
  - perf_retire_cnt increments on each retire.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Package pipe_fwd_pkg:
  - constants for defaults (STAGES, DW, RW, NRP);
  - localparam REG_ZERO;
  - a typedef of the per-stage tag record {valid, we, dest}.
- One sub-module, fwd_match, instantiated per read port: a priority search over the stage tags that returns the hit index, hit flag and pending flag.

Test Plan:
- Reset mid-stream with all stages valid: assert reset for 1 cycle -> stage_valid=0 and in_ready=1 immediately (asynchronous); counters=0.
- Back-to-back ALU ops with STAGES=3, all ready_go=1 and out_allow=1. Op A writes r5=0x1234 with res_valid[0]=1, then op B reads r5 -> fwd_hit[0]=1, fwd_data=0x1234, no stall.
- Load-use: load writes r7 with res_valid[0]=0, next instruction reads r7 -> fwd_stall=1 and in_ready=0. The stall persists until the load reaches the stage with res_valid=1 (data 0xDEAD_BEEF), then hit and accept.
- Youngest wins: stage 0 and stage 2 both hold dest r3, with data 0x1 and 0x2 -> fwd_data=0x1. Reading r0 with a producer of r0 in flight -> fwd_hit=0.
- Backpressure: out_allow=0 for 4 cycles with the pipeline full -> all stages hold, in_ready=0. out_allow then rises -> retire 1 per cycle, in order.
- Flush with flush_mask=3'b011 and all stages valid, same cycle as in_valid=1 -> stages 0 and 1 become invalid, stage 2 is retained or advanced, and the new instruction is dropped. With the macro defined, perf_retire_cnt counts only the surviving instructions.
